// File: rtl/router_pkg.sv
// Shared constants and types for the router slice: port count, the "no port"
// address encoding and the idle-timeout length used by the soft-reset timers.
package router_pkg;

    localparam int unsigned NUM_PORTS      = 3;
    localparam int unsigned TIMEOUT_CYCLES = 30;
    localparam int unsigned TIMER_W        = $clog2(TIMEOUT_CYCLES);

    typedef logic [1:0] port_addr_t;

    localparam port_addr_t ADDR_NONE = 2'b11;

endpackage

// File: rtl/router_sync_timer.sv
// Per-port idle timer: counts consecutive edges where the FIFO holds data but is
// not being read, and emits a one-cycle soft_reset pulse after TIMEOUT_CYCLES.
module router_sync_timer
    import router_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic vld,
    input  logic read_enb,
    output logic soft_reset
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count      <= '0;
            soft_reset <= 1'b0;
        end else if (vld && !read_enb) begin
            // Terminal count wraps to zero, so a sustained idle pulses every TIMEOUT_CYCLES.
            if (count == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                count      <= '0;
                soft_reset <= 1'b1;
            end else begin
                count      <= count + 1'b1;
                soft_reset <= 1'b0;
            end
        end else begin
            count      <= '0;
            soft_reset <= 1'b0;
        end
    end

endmodule

// File: rtl/router_sync.sv
// Router synchroniser: latches the destination address, steers FIFO write enable
// and full flag, and (with SOFT_RESET_TIMEOUT_EN) flushes idle FIFOs on timeout.
module router_sync
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    port_addr_t int_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            int_addr <= ADDR_NONE;
        end else if (detect_add) begin
            int_addr <= data_in;
        end
    end

    // Steering uses the registered address, so a same-cycle detect_add affects only the next cycle.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        case (int_addr)
            2'b00: begin
                write_enb = {2'b00, write_enb_reg};
                fifo_full = full_0;
            end
            2'b01: begin
                write_enb = {1'b0, write_enb_reg, 1'b0};
                fifo_full = full_1;
            end
            2'b10: begin
                write_enb = {write_enb_reg, 2'b00};
                fifo_full = full_2;
            end
            default: begin
                write_enb = '0;
                fifo_full = 1'b0;
            end
        endcase
    end

    assign vld_out_0 = ~empty_0;
    assign vld_out_1 = ~empty_1;
    assign vld_out_2 = ~empty_2;

`ifdef SOFT_RESET_TIMEOUT_EN
    logic [NUM_PORTS-1:0] vld_vec;
    logic [NUM_PORTS-1:0] rd_vec;
    logic [NUM_PORTS-1:0] sr_vec;

    assign vld_vec = {vld_out_2, vld_out_1, vld_out_0};
    assign rd_vec  = {read_enb_2, read_enb_1, read_enb_0};

    for (genvar n = 0; n < NUM_PORTS; n++) begin : g_timer
        router_sync_timer u_timer (
            .clock      (clock),
            .reset      (reset),
            .vld        (vld_vec[n]),
            .read_enb   (rd_vec[n]),
            .soft_reset (sr_vec[n])
        );
    end

    assign soft_reset_0 = sr_vec[0];
    assign soft_reset_1 = sr_vec[1];
    assign soft_reset_2 = sr_vec[2];
`else
    logic unused_read_enb;

    assign unused_read_enb = ^{read_enb_0, read_enb_1, read_enb_2};
    assign soft_reset_0    = 1'b0;
    assign soft_reset_1    = 1'b0;
    assign soft_reset_2    = 1'b0;
`endif

endmodule

// File: tb/tb_router_sync.sv
// Scoreboard bench for router_sync; expectations follow SOFT_RESET_TIMEOUT_EN
// so the same bench covers both builds.
module tb_router_sync;

    logic       clock = 1'b0;
    logic       reset, detect_add, write_enb_reg;
    logic [1:0] data_in;
    logic       full_0, full_1, full_2;
    logic       empty_0, empty_1, empty_2;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

`ifdef SOFT_RESET_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    router_sync dut (
        .clock         (clock),
        .reset         (reset),
        .detect_add    (detect_add),
        .data_in       (data_in),
        .write_enb_reg (write_enb_reg),
        .full_0        (full_0),
        .full_1        (full_1),
        .full_2        (full_2),
        .empty_0       (empty_0),
        .empty_1       (empty_1),
        .empty_2       (empty_2),
        .read_enb_0    (read_enb_0),
        .read_enb_1    (read_enb_1),
        .read_enb_2    (read_enb_2),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .vld_out_0     (vld_out_0),
        .vld_out_1     (vld_out_1),
        .vld_out_2     (vld_out_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] we;
        logic       ff;
        logic [2:0] vld;
        logic [2:0] sr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference state
    logic [1:0] m_addr;
    int         m_cnt[3];
    logic [2:0] m_sr;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [2:0] exp_we();
        if (!write_enb_reg || m_addr == 2'b11) return 3'b000;
        return 3'b001 << m_addr;
    endfunction

    function automatic logic exp_ff();
        case (m_addr)
            2'b00:   return full_0;
            2'b01:   return full_1;
            2'b10:   return full_2;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_addr = 2'b11;
        m_sr   = 3'b000;
        for (int n = 0; n < 3; n++) m_cnt[n] = 0;
    endtask

    task automatic model_edge();
        logic [2:0] emp, rd;
        emp = {empty_2, empty_1, empty_0};
        rd  = {read_enb_2, read_enb_1, read_enb_0};
        if (reset) begin
            model_reset();
            return;
        end
        if (detect_add) m_addr = data_in;
        for (int n = 0; n < 3; n++) begin
            if (TO_EN && !emp[n] && !rd[n]) begin
                if (m_cnt[n] == 29) begin
                    m_cnt[n] = 0;
                    m_sr[n]  = 1'b1;
                end else begin
                    m_cnt[n] = m_cnt[n] + 1;
                    m_sr[n]  = 1'b0;
                end
            end else begin
                m_cnt[n] = 0;
                m_sr[n]  = 1'b0;
            end
        end
    endtask

    // One clock: queue expectations for the current inputs, compare mid-cycle, advance the model.
    task automatic cycle();
        exp_t e;
        e.we  = exp_we();
        e.ff  = exp_ff();
        e.vld = ~{empty_2, empty_1, empty_0};
        e.sr  = m_sr;
        sb.push_back(e);
        @(negedge clock);
        e = sb.pop_front();
        check_eq("write_enb", {5'b0, write_enb}, {5'b0, e.we});
        check_eq("fifo_full", {7'b0, fifo_full}, {7'b0, e.ff});
        check_eq("vld_out", {5'b0, vld_out_2, vld_out_1, vld_out_0}, {5'b0, e.vld});
        check_eq("soft_reset", {5'b0, soft_reset_2, soft_reset_1, soft_reset_0}, {5'b0, e.sr});
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        detect_add = 1'b0; data_in = 2'b11; write_enb_reg = 1'b0;
        {full_2, full_1, full_0}             = 3'b000;
        {empty_2, empty_1, empty_0}          = 3'b111;
        {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        do_reset();
        check_eq("rst_we", {5'b0, write_enb}, 8'h00);
        check_eq("rst_ff", {7'b0, fifo_full}, 8'h00);

        // Address 01 latched, then writes steer to FIFO 1 and fifo_full tracks full_1
        detect_add = 1'b1; data_in = 2'b01;
        cycle();
        detect_add = 1'b0; write_enb_reg = 1'b1; full_1 = 1'b1; full_0 = 1'b0;
        #1;
        check_eq("req028_we", {5'b0, write_enb}, 8'h02);
        check_eq("req028_ff", {7'b0, fifo_full}, 8'h01);
        cycle();
        full_1 = 1'b0; full_0 = 1'b1;
        cycle();

        // Same-cycle detect_add keeps the old address for this cycle
        detect_add = 1'b1; data_in = 2'b00; full_0 = 1'b0; full_2 = 1'b1;
        #1;
        check_eq("req016_we_old", {5'b0, write_enb}, 8'h02);
        cycle();
        detect_add = 1'b0;
        check_eq("req016_we_new", {5'b0, write_enb}, 8'h01);
        cycle();

        // Address 11: no write, no full even with all FIFOs full
        detect_add = 1'b1; data_in = 2'b11;
        cycle();
        detect_add = 1'b0;
        {full_2, full_1, full_0} = 3'b111;
        check_eq("req029_we", {5'b0, write_enb}, 8'h00);
        check_eq("req029_ff", {7'b0, fifo_full}, 8'h00);
        cycle();

        // Sustained idle on port 2: pulse after edges 30 and 60 only
        idle_inputs();
        do_reset();
        empty_2 = 1'b0;
        for (int i = 1; i <= 62; i++) begin
            cycle();
            check_eq("req030_sr2", {7'b0, soft_reset_2}, {7'b0, TO_EN && (i == 30 || i == 60)});
            check_eq("req030_sr10", {6'b0, soft_reset_1, soft_reset_0}, 8'h00);
        end

        // Read strobe at idle edge 20 on port 0 restarts its count
        idle_inputs();
        do_reset();
        empty_0 = 1'b0;
        for (int i = 1; i <= 55; i++) begin
            read_enb_0 = (i == 20);
            cycle();
            check_eq("req031_sr0", {7'b0, soft_reset_0}, {7'b0, TO_EN && i == 50});
        end

        // Reset mid-packet and mid-timeout
        idle_inputs();
        do_reset();
        detect_add = 1'b1; data_in = 2'b10;
        cycle();
        detect_add = 1'b0; write_enb_reg = 1'b1; full_2 = 1'b1; empty_1 = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_eq("req032_we", {5'b0, write_enb}, 8'h00);
        check_eq("req032_ff", {7'b0, fifo_full}, 8'h00);
        for (int i = 1; i <= 31; i++) begin
            cycle();
            check_eq("req032_sr1", {7'b0, soft_reset_1}, {7'b0, TO_EN && i == 30});
        end

        // Random traffic with sparse reads so timeouts occur
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(59) == 0);
            detect_add    = ($urandom_range(7) == 0);
            data_in       = 2'($urandom_range(3));
            write_enb_reg = 1'($urandom_range(1));
            {full_2, full_1, full_0}    = 3'($urandom_range(7));
            {empty_2, empty_1, empty_0} = {($urandom_range(15) == 0), ($urandom_range(15) == 0),
                                           ($urandom_range(15) == 0)};
            {read_enb_2, read_enb_1, read_enb_0} = {($urandom_range(24) == 0), ($urandom_range(24) == 0),
                                                    ($urandom_range(24) == 0)};
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
